rs_issue_select: RTL and testbench

- Sits directly downstream of a bank of NUM_SLOTS ReservationSlot instances and upstream of one functional unit (FU).
- Each cycle, picks one slot that is ready and not yet issued, using round-robin priority.
- Captures the picked slot's operands into a registered issue stage and pulses that slot's instrRecieved.
- Presents the captured operands to the FU under a valid/ready handshake. The output register holds data while the FU stalls.

---
 rtl/rs_pkg.sv | 14 +
 rtl/rs_issue_select_rr_arbiter.sv | 27 ++
 rtl/rs_issue_select.sv | 93 +++++++++
 tb/tb_rs_issue_select.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// rs_pkg: default widths and the reservation-slot entry shared by slots and the issue stage.
package rs_pkg;
  localparam int BIT_WIDTH    = 32;
  localparam int ALU_OP_WIDTH = 7;
  localparam int TAG_WIDTH    = 8;
  localparam int ADDR_WIDTH   = 32;
  typedef struct packed {
    logic [TAG_WIDTH-1:0]    tag;
    logic [ALU_OP_WIDTH-1:0] op;
    logic [BIT_WIDTH-1:0]    vj;
    logic [BIT_WIDTH-1:0]    vk;
    logic [ADDR_WIDTH-1:0]   addr;
  } rs_entry_t;
endpackage

// File: rtl/rs_issue_select_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] winner_o,
  output logic          any_grant_o
);
  logic found;
  always_comb begin
    grant_o     = '0;
    winner_o    = '0;
    found       = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (en_i && !found && req_i[(int'(ptr_i) + k) % N]) begin
        found                              = 1'b1;
        winner_o                           = PW'((int'(ptr_i) + k) % N);
        grant_o[(int'(ptr_i) + k) % N]     = 1'b1;
      end
    end
    any_grant_o = found;
  end
endmodule

// File: rtl/rs_issue_select.sv
// rs_issue_select: round-robin issue from reservation slots into a registered FU issue stage.
// Optional RS_ISSUE_PERF_CNT_EN adds issueCount/stallCount performance counters.
module rs_issue_select
  import rs_pkg::*;
#(
  parameter int NUM_SLOTS    = 4,
  parameter int BIT_WIDTH    = rs_pkg::BIT_WIDTH,
  parameter int ALU_OP_WIDTH = rs_pkg::ALU_OP_WIDTH,
  parameter int TAG_WIDTH    = rs_pkg::TAG_WIDTH,
  parameter int ADDR_WIDTH   = rs_pkg::ADDR_WIDTH
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_SLOTS-1:0]                    slotWr,
  input  logic [NUM_SLOTS-1:0]                    slotBusy,
  input  logic [NUM_SLOTS-1:0]                    slotReady,
  input  logic [NUM_SLOTS-1:0][TAG_WIDTH-1:0]     slotTag,
  input  logic [NUM_SLOTS-1:0][ALU_OP_WIDTH-1:0]  slotOp,
  input  logic [NUM_SLOTS-1:0][BIT_WIDTH-1:0]     slotVj,
  input  logic [NUM_SLOTS-1:0][BIT_WIDTH-1:0]     slotVk,
  input  logic [NUM_SLOTS-1:0][ADDR_WIDTH-1:0]    slotAddr,
  output logic [NUM_SLOTS-1:0]                    instrRecieved,
  output logic                                    issueValid,
  input  logic                                    fuReady,
  output logic [TAG_WIDTH-1:0]                    issueTag,
  output logic [ALU_OP_WIDTH-1:0]                 issueOp,
  output logic [BIT_WIDTH-1:0]                    issueVj,
  output logic [BIT_WIDTH-1:0]                    issueVk,
  output logic [ADDR_WIDTH-1:0]                   issueAddr
`ifdef RS_ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]                             issueCount,
  output logic [31:0]                             stallCount
`endif
);
  localparam int PW = $clog2(NUM_SLOTS);
  logic [NUM_SLOTS-1:0] issued_q, issued_d, eligible, grant;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d, winner;
  logic                 valid_q, valid_d, any_grant, load_en;
  rs_entry_t            entry_q, entry_d;
  assign load_en  = ~valid_q | fuReady;
  assign eligible = slotReady & slotBusy & ~issued_q & ~slotWr;
  rr_arbiter #(.N(NUM_SLOTS), .PW(PW)) u_arb (
    .req_i      (eligible),
    .ptr_i      (rr_ptr_q),
    .en_i       (load_en & ~reset),
    .grant_o    (grant),
    .winner_o   (winner),
    .any_grant_o(any_grant)
  );
  // A rewrite of a slot always wins over a simultaneous grant so the new contents get issued.
  always_comb begin
    issued_d = (issued_q | grant) & ~slotWr;
    rr_ptr_d = !any_grant ? rr_ptr_q : (winner == PW'(NUM_SLOTS - 1)) ? '0 : winner + PW'(1);
    valid_d  = load_en ? any_grant : valid_q;
    entry_d  = any_grant ? '{tag: slotTag[winner], op: slotOp[winner], vj: slotVj[winner],
                             vk: slotVk[winner], addr: slotAddr[winner]} : entry_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      issued_q <= '0;
      rr_ptr_q <= '0;
      valid_q  <= 1'b0;
      entry_q  <= '0;
    end else begin
      issued_q <= issued_d;
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      entry_q  <= entry_d;
    end
  end
  assign instrRecieved = grant;
  assign issueValid    = valid_q;
  assign issueTag      = entry_q.tag;
  assign issueOp       = entry_q.op;
  assign issueVj       = entry_q.vj;
  assign issueVk       = entry_q.vk;
  assign issueAddr     = entry_q.addr;
`ifdef RS_ISSUE_PERF_CNT_EN
  logic [31:0] issue_cnt_q, stall_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_q + 32'(any_grant);
      stall_cnt_q <= stall_cnt_q + 32'(valid_q & ~fuReady);
    end
  end
  assign issueCount = issue_cnt_q;
  assign stallCount = stall_cnt_q;
`endif
endmodule

// File: tb/tb_rs_issue_select.sv
// tb_rs_issue_select: directed self-checking bench for rs_issue_select (honours RS_ISSUE_PERF_CNT_EN).
module tb_rs_issue_select;
  logic             clk = 1'b0;
  logic             reset, fuReady, issueValid;
  logic [3:0]       slotWr, slotBusy, slotReady, instrRecieved;
  logic [3:0][7:0]  slotTag;
  logic [3:0][6:0]  slotOp;
  logic [3:0][31:0] slotVj, slotVk, slotAddr;
  logic [7:0]       issueTag;
  logic [6:0]       issueOp;
  logic [31:0]      issueVj, issueVk, issueAddr;
`ifdef RS_ISSUE_PERF_CNT_EN
  logic [31:0]      issueCount, stallCount;
`endif
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  rs_issue_select dut (
    .clk(clk), .reset(reset), .slotWr(slotWr), .slotBusy(slotBusy), .slotReady(slotReady),
    .slotTag(slotTag), .slotOp(slotOp), .slotVj(slotVj), .slotVk(slotVk), .slotAddr(slotAddr),
    .instrRecieved(instrRecieved), .issueValid(issueValid), .fuReady(fuReady),
    .issueTag(issueTag), .issueOp(issueOp), .issueVj(issueVj), .issueVk(issueVk),
    .issueAddr(issueAddr)
`ifdef RS_ISSUE_PERF_CNT_EN
    , .issueCount(issueCount), .stallCount(stallCount)
`endif
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1; fuReady = 1'b1; slotWr = '0; slotBusy = '0; slotReady = '0;
    for (int i = 0; i < 4; i++) begin
      slotTag[i]  = 8'(8'hA0 + i);
      slotOp[i]   = 7'(i);
      slotVj[i]   = 32'h1000 + 32'(i);
      slotVk[i]   = 32'h2000 + 32'(i);
      slotAddr[i] = 32'h3000 + 32'(i);
    end
    step();
    slotBusy = 4'b0101; slotReady = 4'b0101; #1;
    check("rst_instr", 64'(instrRecieved), 0);
    check("rst_valid", 64'(issueValid), 0);
    check("rst_tag", 64'(issueTag), 0);
    check("rst_vj", 64'(issueVj), 0);
    check("rst_addr", 64'(issueAddr), 0);
    // test 1: slots 0 and 2
    reset = 1'b0; #1;
    check("t1_grant0", 64'(instrRecieved), 64'b0001);
    step();
    check("t1_valid0", 64'(issueValid), 1);
    check("t1_tag0", 64'(issueTag), 64'hA0);
    check("t1_vj0", 64'(issueVj), 64'h1000);
    check("t1_grant2", 64'(instrRecieved), 64'b0100);
    step();
    check("t1_valid2", 64'(issueValid), 1);
    check("t1_tag2", 64'(issueTag), 64'hA2);
    check("t1_op2", 64'(issueOp), 2);
    check("t1_vk2", 64'(issueVk), 64'h2002);
    check("t1_idle_instr", 64'(instrRecieved), 0);
    step();
    check("t1_valid_end", 64'(issueValid), 0);
    check("t1_tag_hold", 64'(issueTag), 64'hA2);
    // test 2: all four eligible, issued in order once each
    reset = 1'b1; slotBusy = 4'hF; slotReady = 4'hF;
    for (int i = 0; i < 4; i++) slotTag[i] = 8'(8'h10 + i);
    step();
    reset = 1'b0; #1;
    check("t2_grant0", 64'(instrRecieved), 64'b0001);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t2_valid%0d", k), 64'(issueValid), 1);
      check($sformatf("t2_tag%0d", k), 64'(issueTag), 64'(8'h10 + k));
      check($sformatf("t2_grant%0d", k + 1), 64'(instrRecieved), (k < 3) ? 64'(1 << (k + 1)) : 64'd0);
    end
    step();
    check("t2_valid_end", 64'(issueValid), 0);
    check("t2_no_regrant", 64'(instrRecieved), 0);
    // test 3: stall holds outputs and blocks grants
    reset = 1'b1; slotBusy = 4'b1010; slotReady = 4'b1010;
    slotTag[1] = 8'h21; slotVj[1] = 32'hDEADBEEF; slotTag[3] = 8'h23;
    step();
    reset = 1'b0; #1;
    check("t3_grant1", 64'(instrRecieved), 64'b0010);
    step();
    check("t3_tag1", 64'(issueTag), 64'h21);
    fuReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t3_stall_instr%0d", k), 64'(instrRecieved), 0);
      check($sformatf("t3_stall_valid%0d", k), 64'(issueValid), 1);
      check($sformatf("t3_stall_tag%0d", k), 64'(issueTag), 64'h21);
      check($sformatf("t3_stall_vj%0d", k), 64'(issueVj), 64'hDEADBEEF);
      step();
    end
    fuReady = 1'b1; #1;
    check("t3_grant3", 64'(instrRecieved), 64'b1000);
    step();
    check("t3_tag3", 64'(issueTag), 64'h23);
    check("t3_no_more", 64'(instrRecieved), 0);
    step();
    check("t3_valid_end", 64'(issueValid), 0);
    // test 4: no re-grant until slotWr reloads the slot
    slotBusy = 4'b1110; slotReady = 4'b1110; slotTag[2] = 8'h32; #1;
    check("t4_grant2", 64'(instrRecieved), 64'b0100);
    step();
    check("t4_tag32", 64'(issueTag), 64'h32);
    check("t4_no_regrant", 64'(instrRecieved), 0);
    step();
    check("t4_valid_end", 64'(issueValid), 0);
    slotWr = 4'b0100; slotTag[2] = 8'h55; #1;
    check("t4_wr_blocks", 64'(instrRecieved), 0);
    step();
    slotWr = '0; #1;
    check("t4_regrant2", 64'(instrRecieved), 64'b0100);
    step();
    check("t4_tag55", 64'(issueTag), 64'h55);
    check("t4_valid55", 64'(issueValid), 1);
    // test 5: write in the cycle slot 0 would win
    reset = 1'b1; slotBusy = 4'b0001; slotReady = 4'b0001; slotTag[0] = 8'h60;
    step();
    reset = 1'b0; slotWr = 4'b0001; #1;
    check("t5_wr_no_grant", 64'(instrRecieved), 0);
    step();
    slotWr = '0; #1;
    check("t5_grant0", 64'(instrRecieved), 64'b0001);
    step();
    check("t5_tag60", 64'(issueTag), 64'h60);
    // test 6: reset during stall
    fuReady = 1'b0; slotBusy = 4'b0011; slotReady = 4'b0011; slotTag[1] = 8'h61; #1;
    check("t6_stall_instr", 64'(instrRecieved), 0);
    step();
    check("t6_stall_valid", 64'(issueValid), 1);
`ifdef RS_ISSUE_PERF_CNT_EN
    check("t6_issue_cnt", 64'(issueCount), 1);
    check("t6_stall_cnt", 64'(stallCount), 1);
`endif
    reset = 1'b1; #1;
    check("t6_rst_instr", 64'(instrRecieved), 0);
    step();
    reset = 1'b0; fuReady = 1'b1;
    check("t6_valid", 64'(issueValid), 0);
    check("t6_tag", 64'(issueTag), 0);
    check("t6_op", 64'(issueOp), 0);
    check("t6_vj", 64'(issueVj), 0);
    check("t6_vk", 64'(issueVk), 0);
    check("t6_addr", 64'(issueAddr), 0);
`ifdef RS_ISSUE_PERF_CNT_EN
    check("t6_issue_cnt_rst", 64'(issueCount), 0);
    check("t6_stall_cnt_rst", 64'(stallCount), 0);
`endif
    #1;
    check("t6_ptr_rst_grant0", 64'(instrRecieved), 64'b0001);
    step();
    check("t6_tag60", 64'(issueTag), 64'h60);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
